// File: rtl/mpc_mac_pkg.sv
// Shared widths, types and the round/saturate helper for the MPC dot-product
// accumulator.
package mpc_mac_pkg;

    localparam int PROD_W     = 34;
    localparam int ACC_W      = 40;
    localparam int OUT_W      = 21;
    localparam int FRAC_SHIFT = 12;
    localparam int MAX_TERMS  = 64;

    typedef enum logic [0:0] {IDLE, ACC} acc_state_t;

    // Tag that travels alongside an operand pair through the multiplier.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    // Rounded result plus the clip flag.
    typedef struct packed {
        logic [OUT_W-1:0] res;
        logic             sat;
    } rs_t;

    // Clip bounds, expressed at ACC_W+1 bits so they compare directly with
    // the rounded sum.
    localparam logic signed [ACC_W:0] R_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] R_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Round half toward +inf, rescale by 'shift', clip to OUT_W. The extra
    // bit keeps the rounding add from wrapping at the top of the range.
    // 'shift' must be at least 1.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] sum,
                                      input int                      shift);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] r;
        rs_t                   o;
        ext           = {sum[ACC_W-1], sum};
        half          = '0;
        half[shift-1] = 1'b1;
        r             = (ext + half) >>> shift;
        if (r > R_MAX) begin
            o.res = R_MAX[OUT_W-1:0];
            o.sat = 1'b1;
        end else if (r < R_MIN) begin
            o.res = R_MIN[OUT_W-1:0];
            o.sat = 1'b1;
        end else begin
            o.res = r[OUT_W-1:0];
            o.sat = 1'b0;
        end
        return o;
    endfunction

endpackage

// File: rtl/mpc_tag_delay.sv
// MUL_LAT-deep {vld, last} delay line that tracks the multiplier pipeline so
// the tag emerges in the same cycle as its product.
module mpc_tag_delay
    import mpc_mac_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [MUL_LAT-1:0] vld_pipe;

    // Shift on ce only, so stalls freeze tags and products together.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (ce) begin
            vld_pipe[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tag_out = vld_pipe[MUL_LAT-1];

endmodule

// File: rtl/mpc_dot_acc_sat.sv
// Row accumulator behind the 21x13 multiplier: sums the products of one
// matrix row, then rounds and saturates the sum back to the 21-bit format.
module mpc_dot_acc_sat #(
    parameter int MUL_LAT    = 3,
    parameter int PROD_W     = mpc_mac_pkg::PROD_W,
    parameter int ACC_W      = mpc_mac_pkg::ACC_W,
    parameter int OUT_W      = mpc_mac_pkg::OUT_W,
    parameter int FRAC_SHIFT = mpc_mac_pkg::FRAC_SHIFT,
    parameter int MAX_TERMS  = mpc_mac_pkg::MAX_TERMS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     op_vld,
    input  logic                     op_last,
    input  logic signed [PROD_W-1:0] p,
    output logic                     res_vld,
    output logic signed [OUT_W-1:0]  res,
    output logic                     res_sat,
    output logic                     res_ovf
);

    import mpc_mac_pkg::*;

    // The count saturates one past the legal maximum, which is enough to flag
    // an over-long row without ever wrapping.
    localparam int                CNT_W   = $clog2(MAX_TERMS + 2);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

    tag_t                     tag_in;
    tag_t                     t_tag;
    acc_state_t               state;
    acc_state_t               state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  p_ext;
    logic signed [ACC_W-1:0]  sum_in;
    logic        [CNT_W-1:0]  cnt;
    logic        [CNT_W-1:0]  cnt_in;
    logic                     emit;
    logic                     s1_vld;
    logic                     s1_ovf;
    logic signed [ACC_W-1:0]  s1_sum;
    rs_t                      rs;

    // last is only meaningful alongside vld; mask it so a stray last can't
    // close a row.
    assign tag_in = '{vld: op_vld, last: op_vld & op_last};

    mpc_tag_delay #(.MUL_LAT(MUL_LAT)) u_tag (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .tag_in  (tag_in),
        .tag_out (t_tag)
    );

    assign p_ext = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};

    // Next-state and running sum: a first term replaces acc, later terms add.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        sum_in    = p_ext;
        cnt_in    = CNT_W'(1);
        if (state == ACC) begin
            sum_in = acc + p_ext;
            cnt_in = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
        end
        if (t_tag.vld) begin
            emit      = t_tag.last;
            state_nxt = t_tag.last ? IDLE : ACC;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)     state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    // Accumulator and term count; gaps (t_vld=0) simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (ce && t_tag.vld) begin
            acc <= sum_in;
            cnt <= cnt_in;
        end
    end

    // S1 captures the finished row sum on the same edge the accumulator
    // restarts, so back-to-back rows need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_sum <= '0;
            s1_ovf <= 1'b0;
        end else if (ce) begin
            s1_vld <= emit;
            if (emit) begin
                s1_sum <= sum_in;
                s1_ovf <= (cnt_in > CNT_MAX);
            end
        end
    end

    assign rs = round_sat(s1_sum, FRAC_SHIFT);

    // S2 registers the rounded/clipped result; res_vld pulses for one
    // ce-qualified cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld <= 1'b0;
            res     <= '0;
            res_sat <= 1'b0;
            res_ovf <= 1'b0;
        end else if (ce) begin
            res_vld <= s1_vld;
            if (s1_vld) begin
                res     <= rs.res;
                res_sat <= rs.sat;
                res_ovf <= s1_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mpc_dot_acc_sat.sv
// Randomised and directed checks of mpc_dot_acc_sat against a row-level
// arithmetic model, with an ideal 3-stage multiplier stand-in driving p.
module tb_mpc_dot_acc_sat;

    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               op_vld;
    logic               op_last;
    logic signed [33:0] p;
    logic               res_vld;
    logic signed [20:0] res;
    logic               res_sat;
    logic               res_ovf;

    always #5 clk = ~clk;

    mpc_dot_acc_sat dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .op_vld  (op_vld),
        .op_last (op_last),
        .p       (p),
        .res_vld (res_vld),
        .res     (res),
        .res_sat (res_sat),
        .res_ovf (res_ovf)
    );

    typedef struct {
        longint due;
        longint res;
        bit     sat;
        bit     ovf;
    } exp_t;

    exp_t   expq[$];
    longint ce_cnt   = 0;
    longint row_sum  = 0;
    int     row_n    = 0;
    longint mq[3]    = '{0, 0, 0};
    int     n_chk    = 0;
    int     n_fail   = 0;
    bit     chk_on   = 0;
    longint seen_due = -1;
    longint log_res[$];
    bit     log_sat[$];
    bit     log_ovf[$];
    longint log_at[$];
    longint op_at;

    task automatic check(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Row result from plain arithmetic: floor((sum + 2048) / 4096), clipped.
    function automatic void model_row(input longint s, output longint r, output bit sat);
        r   = (s + 2048) >>> 12;
        sat = 1'b0;
        if (r > 1048575) begin
            r   = 1048575;
            sat = 1'b1;
        end else if (r < -1048576) begin
            r   = -1048576;
            sat = 1'b1;
        end
    endfunction

    // One clock: drive inputs, let the edge happen, then update the model.
    task automatic cyc(input bit c, input bit v, input bit l, input longint val, input bit r);
        longint rr;
        bit     ss;
        ce = c; op_vld = v; op_last = l; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            row_sum = 0;
            row_n   = 0;
            expq.delete();
        end
        if (c) begin
            mq[2] = mq[1];
            mq[1] = mq[0];
            mq[0] = v ? val : longint'($urandom);
            if (!r) begin
                ce_cnt++;
                if (v) begin
                    row_sum += val;
                    row_n++;
                    op_at = ce_cnt;
                    if (l) begin
                        model_row(row_sum, rr, ss);
                        expq.push_back('{ce_cnt + LAT + 1, rr, ss, row_n > 64});
                        row_sum = 0;
                        row_n   = 0;
                    end
                end
            end
        end
        p = mq[2][33:0];
    endtask

    task automatic op(input longint v, input bit l);
        cyc(1, 1, l, v, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic clr_log();
        log_res.delete(); log_sat.delete(); log_ovf.delete(); log_at.delete();
    endtask

    task automatic lit(input string nm, input int idx, input longint r, input bit s, input bit o);
        n_chk++;
        if (idx >= log_res.size()) begin
            n_fail++;
            $display("FAIL %s: result %0d missing, got %0d results", nm, idx, log_res.size());
        end else begin
            n_chk--;
            if (!o) check({nm, " res"}, log_res[idx], r);
            check({nm, " sat"}, log_sat[idx], s);
            check({nm, " ovf"}, log_ovf[idx], o);
        end
    endtask

    // Per-cycle compare against the model's schedule of due results.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (chk_on) begin
            while (expq.size() > 0 && expq[0].due < ce_cnt) void'(expq.pop_front());
            ev = (expq.size() > 0) && (expq[0].due == ce_cnt);
            check("res_vld", res_vld, ev);
            if (ev && res_vld) begin
                e = expq[0];
                check("res_ovf", res_ovf, e.ovf);
                if (!e.ovf) begin
                    check("res", res, e.res);
                    check("res_sat", res_sat, e.sat);
                end
                if (e.due != seen_due) begin
                    seen_due = e.due;
                    log_res.push_back(res);
                    log_sat.push_back(res_sat);
                    log_ovf.push_back(res_ovf);
                    log_at.push_back(ce_cnt);
                end
            end
        end
    end

    initial begin
        longint v;
        longint stall_res;
        ce = 0; op_vld = 0; op_last = 0; rst = 1; p = '0;
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        @(negedge clk);
        check("reset res_vld", res_vld, 0);
        check("reset res", res, 0);
        check("reset res_sat", res_sat, 0);
        check("reset res_ovf", res_ovf, 0);
        chk_on = 1;
        idle(2);

        // Basic row and latency.
        clr_log();
        op(4096, 0); op(8192, 0); op(-2048, 1);
        v = op_at;
        idle(8);
        check("row3 count", log_res.size(), 1);
        lit("row3", 0, 3, 0, 0);
        if (log_at.size() > 0) check("row3 latency", log_at[0] - v, 4);

        // Single-term rows, back-to-back.
        clr_log();
        op(2048, 1);
        v = op_at;
        op(-2048, 1);
        idle(8);
        lit("single+", 0, 1, 0, 0);
        lit("single-", 1, 0, 0, 0);
        if (log_at.size() > 1) begin
            check("single latency", log_at[0] - v, 4);
            check("single spacing", log_at[1] - log_at[0], 1);
        end

        // Two-term rows with no gap.
        clr_log();
        op(4096, 0); op(4096, 1); op(-8192, 0); op(-4096, 1);
        idle(8);
        lit("b2b a", 0, 2, 0, 0);
        lit("b2b b", 1, -3, 0, 0);
        if (log_at.size() > 1) check("b2b spacing", log_at[1] - log_at[0], 2);

        // Saturation at both rails, maximum legal row length.
        clr_log();
        for (int i = 0; i < 64; i++) op(64'sd8589934591, i == 63);
        for (int i = 0; i < 64; i++) op(-64'sd8589934592, i == 63);
        idle(8);
        lit("sat hi", 0, 1048575, 1, 0);
        lit("sat lo", 1, -1048576, 1, 0);

        // One term too many.
        clr_log();
        for (int i = 0; i < 65; i++) op(1, i == 64);
        idle(8);
        lit("ovf", 0, 0, 0, 1);

        // Stall mid-row must match the unstalled result.
        clr_log();
        op(4096, 0); op(8192, 0); op(12288, 0); op(16384, 1);
        idle(8);
        lit("nostall", 0, 10, 0, 0);
        stall_res = (log_res.size() > 0) ? log_res[0] : 0;
        clr_log();
        op(4096, 0); op(8192, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 12288, 0);
        op(12288, 0); op(16384, 1);
        idle(8);
        check("stall count", log_res.size(), 1);
        lit("stall", 0, stall_res, 0, 0);

        // Reset mid-row drops the row; the next clean row is unaffected.
        clr_log();
        op(4096, 0); op(4096, 0);
        cyc(1, 0, 0, 0, 1);
        idle(8);
        check("rst drop count", log_res.size(), 0);
        op(4096, 1);
        idle(8);
        lit("post rst", 0, 1, 0, 0);

        // Random rows with gaps, stalls and the occasional reset.
        for (int row = 0; row < 300; row++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                if ($urandom_range(0, 6) == 0)
                    for (int k = $urandom_range(1, 3); k > 0; k--)
                        cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
                if ($urandom_range(0, 99) < 2) cyc($urandom_range(0, 1), 0, 0, 0, 1);
                v = longint'({$urandom, $urandom});
                if ($urandom_range(0, 2) == 0) v = (v <<< 30) >>> 30;
                else                          v = (v <<< 42) >>> 42;
                op(v, t == n - 1);
            end
        end
        idle(10);
        check("queue drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mpc_dot_acc_sat.md
# mpc_dot_acc_sat

Dot-product accumulator placed directly downstream of the signed 21×13 DSP48 multiplier in the implicit MPC datapath. It aligns a valid/last tag with the multiplier's fixed pipeline latency and sums the 34-bit products of one row. It then rounds the row sum back to the 21-bit fixed-point format and saturates it, producing one result per matrix-row × vector dot product. The output feeds the MPC solver's vector registers.

## Interface

Parameters:
- MUL_LAT, 3 — register stages from multiplier operand input to product output.
- PROD_W, 34 — product width (signed).
- ACC_W, 40 — accumulator width (signed).
- OUT_W, 21 — result width (signed).
- FRAC_SHIFT, 12 — right shift applied to the row sum (fixed-point rescale).
- MAX_TERMS, 64 — maximum legal terms per row, equal to 2^(ACC_W−PROD_W).

Ports:
- clk, in, 1 — single clock, rising edge.
- rst, in, 1 — synchronous, active-high reset.
- ce, in, 1 — clock enable, shared with the multiplier. When low, all state holds.
- op_vld, in, 1 — a/b operands are presented to the multiplier this cycle.
- op_last, in, 1 — this operand pair is the last term of the row. Meaningful only with op_vld.
- p, in, PROD_W — multiplier product output.
- res_vld, out, 1 — res and res_ovf are valid. Sampled only when ce=1.
- res, out, OUT_W — rounded, saturated row sum.
- res_sat, out, 1 — res was clipped.
- res_ovf, out, 1 — the row had more than MAX_TERMS terms, so the accumulator result is undefined.

## Operation

- **Tag pipe:** a MUL_LAT-deep shift register of {vld, last}, advancing only when ce=1. Its output {t_vld, t_last} is aligned with p.
- **Accumulator:** states IDLE and ACC.
  - IDLE, t_vld=1: acc ← sext(p), cnt ← 1. Go to ACC, or stay in IDLE and emit when t_last=1 (single-term row).
  - ACC, t_vld=1: acc ← acc + sext(p), cnt ← cnt+1 (saturating at MAX_TERMS+1). When t_last=1, emit and return to IDLE.
  - ACC, t_vld=0: hold. Gaps inside a row are legal.
- **Emit:** the final sum (acc + p, or sext(p) for a single term) and the ovf bit (cnt > MAX_TERMS after the add) are registered into stage S1, with s1_vld=1.
- **Round/saturate stage S2:**
  - r = (s1_sum + 2^(FRAC_SHIFT−1)) >>> FRAC_SHIFT, computed at ACC_W+1 bits. This is round half toward +∞.
  - r > 2^(OUT_W−1)−1 → res = 2^(OUT_W−1)−1, res_sat=1.
  - r < −2^(OUT_W−1) → res = −2^(OUT_W−1), res_sat=1.
  - Otherwise res = r[OUT_W−1:0] and res_sat=0.
  - res_vld = s1_vld.
- **Back-to-back rows:** a last term immediately followed by a first term needs no bubble. The emit path and the accumulator restart happen on the same edge.
- **Accumulator width:** it never wraps within MAX_TERMS terms. Beyond MAX_TERMS terms, res_ovf=1 and res is unspecified.

## Timing

- Operands and op_vld are presented in cycle t (ce continuously high). p is valid in t+MUL_LAT, S1 is loaded at the end of t+MUL_LAT, and res_vld=1 in cycle t+MUL_LAT+2 for last terms. Latency from the last op_vld to res_vld is MUL_LAT+2 = 5 cycles.
- Throughput is one term per cycle. Minimum row spacing is one cycle.
- res_vld is a one-cycle pulse (counted in ce=1 cycles). It stays asserted while ce=0 and drops on the next ce=1 edge with no new result.
- **Reset:** the tag pipe, acc, cnt, S1 and S2 are cleared, and the state goes to IDLE. Output reset values: res_vld=0, res=0, res_sat=0, res_ovf=0.
- Reset mid-row discards all in-flight terms. Products still in the multiplier are ignored because their tags are cleared.
- rst has priority over ce.

## Structure

- Package mpc_mac_pkg holds PROD_W, ACC_W, OUT_W, FRAC_SHIFT, MAX_TERMS defaults, the acc_state_t enum {IDLE, ACC}, and a round_sat function (sum, shift → res, sat).
- Sub-module mpc_tag_delay: a parameterized MUL_LAT-deep {vld, last} shift register with ce and synchronous reset.

## Test plan

- Row of products 4096, 8192, −2048 (last on the third) → sum 10240, res=3, res_sat=0, res_vld 5 cycles after the third op_vld.
- Single-term rows p=2048 and p=−2048 → res=1, then res=0 (half-up rounding). Each emits with no extra latency.
- Two 2-term rows back-to-back with no gap: {4096, 4096} and {−8192, −4096} → res=2, then res=−3, on consecutive-row spacing with no dropped term.
- Saturation: 64 terms of p=2^33−1 → res=1048575, res_sat=1. 64 terms of p=−2^33 → res=−1048576, res_sat=1. res_ovf=0 in both.
- 65 terms of p=1 → res_ovf=1.
- ce held low 3 cycles mid-row → no term lost or duplicated, and the result is identical to the no-stall run.
- rst asserted for 1 cycle after 2 of 4 terms → no res_vld for that row. The next clean row {4096} yields res=1.
